// File: rtl/fp_to_fixed_pipe.sv
// fp_to_fixed_pipe: pipelined IEEE-754 single -> signed fixed point with rounding and saturation
module fp_to_fixed_pipe #(
    parameter int OUT_W      = 32,
    parameter int FRAC_BITS  = 30,
    parameter int ROUND_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             in_valid,
    input  logic [31:0]      dataa,
    output logic [OUT_W-1:0] result,
    output logic             out_valid,
    output logic             overflow,
    output logic             nan_flag
);
    localparam logic [1:0]       C_ZERO = 2'd0;
    localparam logic [1:0]       C_NORM = 2'd1;
    localparam logic [1:0]       C_INF  = 2'd2;
    localparam logic [1:0]       C_NAN  = 2'd3;
    localparam logic [OUT_W:0]   LIM    = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MAX    = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN    = {1'b1, {(OUT_W-1){1'b0}}};

    logic              v1_q, v1_d, s1_q, s1_d;
    logic [1:0]        c1_q, c1_d, cls_in;
    logic [23:0]       m1_q, m1_d;
    logic signed [9:0] sh1_q, sh1_d;

    logic              v2_q, v2_d, s2_q, s2_d, g2_q, g2_d, st2_q, st2_d, po2_q, po2_d;
    logic [1:0]        c2_q, c2_d;
    logic [OUT_W:0]    mag2_q, mag2_d;

    logic              ov_q, ov_d, ovf_q, ovf_d, nan_q, nan_d;
    logic [OUT_W-1:0]  res_q, res_d;

    logic [9:0]        rs;
    logic [47:0]       ext;
    logic [OUT_W:0]    lw, mag_n;
    logic              neg, big_r, po_n, g_n, st_n;

    logic              inc, ovf_num;
    logic [OUT_W+1:0]  rnd;
    logic [OUT_W-1:0]  sat, num, res_n;

    // S1: unpack sign/exponent/mantissa, classify, and compute the alignment shift
    always_comb begin
        cls_in = (dataa[30:23] == 8'd0) ? C_ZERO :
                 (dataa[30:23] == 8'hFF) ? ((|dataa[22:0]) ? C_NAN : C_INF) : C_NORM;
        v1_d   = clk_en ? in_valid : v1_q;
        s1_d   = clk_en ? dataa[31] : s1_q;
        c1_d   = clk_en ? cls_in : c1_q;
        m1_d   = clk_en ? {1'b1, dataa[22:0]} : m1_q;
        sh1_d  = clk_en ? 10'(int'(dataa[30:23]) - 150 + FRAC_BITS) : sh1_q;
    end

    // S2: align the mantissa into the magnitude, keeping guard/sticky and a pre-overflow flag
    always_comb begin
        neg    = sh1_q[9];
        rs     = -sh1_q;
        ext    = {m1_q, 24'd0} >> rs[4:0];
        lw     = (OUT_W+1)'(m1_q) << sh1_q[8:0];
        big_r  = int'(rs) >= 25;
        po_n   = int'(sh1_q) + 23 > OUT_W;
        mag_n  = !neg ? lw : big_r ? '0 : (OUT_W+1)'(ext[47:24]);
        g_n    = neg && !big_r && ext[23];
        st_n   = neg && (big_r ? |m1_q : |ext[22:0]);
        v2_d   = clk_en ? v1_q : v2_q;
        s2_d   = clk_en ? s1_q : s2_q;
        c2_d   = clk_en ? c1_q : c2_q;
        mag2_d = clk_en ? mag_n : mag2_q;
        g2_d   = clk_en ? g_n : g2_q;
        st2_d  = clk_en ? st_n : st2_q;
        po2_d  = clk_en ? po_n : po2_q;
    end

    // S3: round, apply sign, saturate, and resolve special classes; bubbles drive zeros
    always_comb begin
        inc     = (ROUND_MODE == 1) && g2_q && (st2_q || mag2_q[0]);
        rnd     = {1'b0, mag2_q} + (OUT_W+2)'(inc);
        ovf_num = po2_q || (s2_q ? rnd > {1'b0, LIM} : rnd >= {1'b0, LIM});
        sat     = s2_q ? MIN : MAX;
        num     = ovf_num ? sat : s2_q ? OUT_W'(-rnd) : rnd[OUT_W-1:0];
        res_n   = (c2_q == C_NORM) ? num : (c2_q == C_INF) ? sat : '0;
        ov_d    = clk_en ? v2_q : ov_q;
        res_d   = clk_en ? (v2_q ? res_n : '0) : res_q;
        ovf_d   = clk_en ? (v2_q && ((c2_q == C_NORM) ? ovf_num : (c2_q == C_INF))) : ovf_q;
        nan_d   = clk_en ? (v2_q && (c2_q == C_NAN)) : nan_q;
    end

    // Pipeline registers; reset wins over clk_en and drops every in-flight sample
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q   <= 1'b0;
            s1_q   <= 1'b0;
            c1_q   <= C_ZERO;
            m1_q   <= '0;
            sh1_q  <= '0;
            v2_q   <= 1'b0;
            s2_q   <= 1'b0;
            c2_q   <= C_ZERO;
            mag2_q <= '0;
            g2_q   <= 1'b0;
            st2_q  <= 1'b0;
            po2_q  <= 1'b0;
            ov_q   <= 1'b0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            nan_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            s1_q   <= s1_d;
            c1_q   <= c1_d;
            m1_q   <= m1_d;
            sh1_q  <= sh1_d;
            v2_q   <= v2_d;
            s2_q   <= s2_d;
            c2_q   <= c2_d;
            mag2_q <= mag2_d;
            g2_q   <= g2_d;
            st2_q  <= st2_d;
            po2_q  <= po2_d;
            ov_q   <= ov_d;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
            nan_q  <= nan_d;
        end
    end

    assign result    = res_q;
    assign out_valid = ov_q;
    assign overflow  = ovf_q;
    assign nan_flag  = nan_q;
endmodule
